// File: rtl/ifu_line_prefetch.sv
// rtl/ifu_line_prefetch.sv - instruction fetch unit with line refill over AXI4 read and an instruction queue toward IDU
module ifu_line_prefetch #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IQ_DEPTH   = 4,
  parameter logic [31:0] RESET_PC   = 32'h3000_0000,
  parameter logic [3:0]  BURST_LO   = 4'hA,
  parameter logic [3:0]  BURST_HI   = 4'hB,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_fault,
  output logic [31:0]              ic_addr,
  input  logic                     ic_hit,
  input  logic [31:0]              ic_data,
  output logic                     refill_valid,
  output logic [31:0]              refill_addr,
  output logic [32*LINE_WORDS-1:0] refill_data,
  output logic                     arvalid,
  input  logic                     arready,
  output logic [31:0]              araddr,
  output logic [3:0]               arid,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  input  logic                     rvalid,
  output logic                     rready,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast
);

  localparam int unsigned BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned PW = $clog2(IQ_DEPTH);
  localparam logic [31:0]   LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [PW:0]   IQ_FULL   = (PW + 1)'(IQ_DEPTH);

  typedef enum logic [1:0] {S_LOOKUP, S_AR, S_R, S_FILL} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             fetch_pc_q, fetch_pc_d;
  logic [31:0]             base_q, base_d;
  logic                    burst_q, burst_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    fault_acc_q, fault_acc_d;
  logic                    halted_q, halted_d;
  logic                    redir_seen_q, redir_seen_d;
  logic [32*LINE_WORDS-1:0] refill_data_q, refill_data_d;

  logic [31:0] iq_pc    [IQ_DEPTH];
  logic [31:0] iq_inst  [IQ_DEPTH];
  logic        iq_fault [IQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;

  logic        iq_full;
  logic        enq;
  logic [31:0] enq_inst;
  logic        enq_fault;
  logic        deq;

  assign iq_full   = (count_q == IQ_FULL);
  assign out_valid = (count_q != '0) && !redirect_valid;
  assign deq       = out_valid && out_ready;
  assign out_pc    = iq_pc[rd_ptr_q];
  assign out_inst  = iq_inst[rd_ptr_q];
  assign out_fault = iq_fault[rd_ptr_q];

  assign ic_addr     = fetch_pc_q;
  assign refill_addr = base_q;
  assign refill_data = refill_data_q;
  assign arid        = AXI_ID;
  assign arsize      = 3'b010;
  assign araddr      = burst_q ? base_q : base_q + (32'(beat_q) << 2);
  assign arlen       = burst_q ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arburst     = burst_q ? 2'b01 : 2'b00;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    base_d        = base_q;
    burst_d       = burst_q;
    beat_d        = beat_q;
    fault_acc_d   = fault_acc_q;
    halted_d      = halted_q;
    redir_seen_d  = redir_seen_q;
    refill_data_d = refill_data_q;
    enq           = 1'b0;
    enq_inst      = ic_data;
    enq_fault     = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    refill_valid  = 1'b0;

    case (state_q)
      S_LOOKUP: begin
        if (!halted_q && !redirect_valid && !iq_full) begin
          if (ic_hit) begin
            enq        = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            base_d       = fetch_pc_q & LINE_MASK;
            burst_d      = (fetch_pc_q[31:28] >= BURST_LO) && (fetch_pc_q[31:28] <= BURST_HI);
            beat_d       = '0;
            fault_acc_d  = 1'b0;
            redir_seen_d = 1'b0;
            state_d      = S_AR;
          end
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          for (int i = 0; i < int'(LINE_WORDS); i++) begin
            if (beat_q == BW'(i)) refill_data_d[32*i +: 32] = rdata;
          end
          if (rresp != 2'b00) fault_acc_d = 1'b1;
          beat_d = beat_q + 1'b1;
          if (burst_q) begin
            if (rlast) state_d = S_FILL;
          end else if (beat_q == LAST_BEAT) begin
            state_d = S_FILL;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_FILL: begin
        // A faulted line is only reported if the fetch path it belongs to is still live
        if (!fault_acc_q) begin
          refill_valid = 1'b1;
          state_d      = S_LOOKUP;
        end else if (redir_seen_q || redirect_valid) begin
          state_d = S_LOOKUP;
        end else if (!iq_full) begin
          enq       = 1'b1;
          enq_inst  = 32'h0;
          enq_fault = 1'b1;
          halted_d  = 1'b1;
          state_d   = S_LOOKUP;
        end
      end
      default: state_d = S_LOOKUP;
    endcase

    if (redirect_valid) begin
      fetch_pc_d   = redirect_pc;
      halted_d     = 1'b0;
      redir_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOOKUP;
      fetch_pc_q    <= RESET_PC;
      base_q        <= '0;
      burst_q       <= 1'b0;
      beat_q        <= '0;
      fault_acc_q   <= 1'b0;
      halted_q      <= 1'b0;
      redir_seen_q  <= 1'b0;
      refill_data_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      base_q        <= base_d;
      burst_q       <= burst_d;
      beat_q        <= beat_d;
      fault_acc_q   <= fault_acc_d;
      halted_q      <= halted_d;
      redir_seen_q  <= redir_seen_d;
      refill_data_q <= refill_data_d;
    end
  end

  // No enqueue bypass on a full queue: a same-cycle dequeue does not free the slot early
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect_valid) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW + 1)'(enq) - (PW + 1)'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      iq_pc[wr_ptr_q]    <= fetch_pc_q;
      iq_inst[wr_ptr_q]  <= enq_inst;
      iq_fault[wr_ptr_q] <= enq_fault;
    end
  end

endmodule

// File: tb/tb_ifu_line_prefetch.sv
// tb/tb_ifu_line_prefetch.sv - directed bench for ifu_line_prefetch with an AXI read slave and I-cache tag model
module tb_ifu_line_prefetch;

  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid, out_ready, out_fault;
  logic [31:0]   out_pc, out_inst;
  logic [31:0]   ic_addr;
  logic          ic_hit;
  logic [31:0]   ic_data;
  logic          refill_valid;
  logic [31:0]   refill_addr;
  logic [32*LW-1:0] refill_data;
  logic          arvalid, arready;
  logic [31:0]   araddr;
  logic [3:0]    arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid, rready, rlast;
  logic [31:0]   rdata;
  logic [1:0]    rresp;

  ifu_line_prefetch #(
    .LINE_WORDS(LW), .IQ_DEPTH(4), .RESET_PC(32'h3000_0000),
    .BURST_LO(4'h3), .BURST_HI(4'hB), .AXI_ID(4'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_fault(out_fault),
    .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_data(ic_data),
    .refill_valid(refill_valid), .refill_addr(refill_addr), .refill_data(refill_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc;
  int r_beats;

  logic [31:0] obs_pc[$];
  logic [31:0] obs_inst[$];
  logic        obs_fault[$];
  int          obs_cyc[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [1:0]  ar_burst_q[$];
  logic [3:0]  ar_id_q[$];
  logic [2:0]  ar_size_q[$];
  logic [31:0] rf_addr_q[$];
  logic [32*LW-1:0] rf_data_q[$];

  logic [31:0] tag[8];
  logic        tag_v[8];
  int          tag_ptr;

  logic [31:0] err_addr;
  logic        s_busy;
  logic [31:0] s_addr;
  int          s_len, s_idx;
  logic        s_burst;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic lookup(input logic [31:0] a);
    logic h = 1'b0;
    for (int i = 0; i < 8; i++) if (tag_v[i] && tag[i] == (a & 32'hFFFF_FFF0)) h = 1'b1;
    return h;
  endfunction

  task automatic install(input logic [31:0] a);
    tag[tag_ptr]   = a & 32'hFFFF_FFF0;
    tag_v[tag_ptr] = 1'b1;
    tag_ptr = (tag_ptr + 1) % 8;
  endtask

  task automatic refresh_ic();
    ic_hit  = lookup(ic_addr);
    ic_data = mem_f(ic_addr);
  endtask

  task automatic drive_beat();
    logic [31:0] a;
    a = s_burst ? s_addr + 32'(4 * s_idx) : s_addr;
    rvalid = 1'b1;
    rdata  = mem_f(a);
    rresp  = (a == err_addr) ? 2'b10 : 2'b00;
    rlast  = (s_idx == s_len);
  endtask

  // One clock: record what the coming edge will do, then play the AXI slave and cache at the negedge
  task automatic step();
    logic hs_ar, hs_r;
    #1;
    hs_ar = arvalid && arready;
    hs_r  = rvalid && rready;
    if (out_valid && out_ready) begin
      obs_pc.push_back(out_pc); obs_inst.push_back(out_inst);
      obs_fault.push_back(out_fault); obs_cyc.push_back(cyc);
    end
    if (hs_ar) begin
      ar_addr_q.push_back(araddr); ar_len_q.push_back(arlen); ar_burst_q.push_back(arburst);
      ar_id_q.push_back(arid); ar_size_q.push_back(arsize);
      s_addr = araddr; s_len = int'(arlen); s_burst = (arburst == 2'b01);
    end
    if (hs_r) r_beats++;
    if (refill_valid) begin
      rf_addr_q.push_back(refill_addr); rf_data_q.push_back(refill_data);
      install(refill_addr);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (hs_ar) begin
      arready = 1'b0; s_idx = 0; s_busy = 1'b1; drive_beat();
    end else if (hs_r) begin
      s_idx++;
      if (s_idx > s_len) begin
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; s_busy = 1'b0;
      end else begin
        drive_beat();
      end
    end
    if (!s_busy && arvalid && !arready) arready = 1'b1;
    refresh_ic();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    ic_hit = 1'b0; ic_data = '0; err_addr = '1; s_busy = 1'b0; s_idx = 0; s_len = 0;
    s_addr = '0; s_burst = 1'b0; cyc = 0; r_beats = 0; tag_ptr = 0;
    for (int i = 0; i < 8; i++) begin tag[i] = '0; tag_v[i] = 1'b0; end
    obs_pc.delete(); obs_inst.delete(); obs_fault.delete(); obs_cyc.delete();
    ar_addr_q.delete(); ar_len_q.delete(); ar_burst_q.delete(); ar_id_q.delete(); ar_size_q.delete();
    rf_addr_q.delete(); rf_data_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    refresh_ic();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL reset_rready: got %b want 0", rready); end
    total++; if (refill_valid !== 1'b0) begin bad++; $display("FAIL reset_refill_valid: got %b want 0", refill_valid); end
    total++; if (refill_data !== '0) begin bad++; $display("FAIL reset_refill_data: got %h want 0", refill_data); end
    total++; if (ic_addr !== 32'h3000_0000) begin bad++; $display("FAIL reset_pc: got %h want 30000000", ic_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_start();
    logic [32*LW-1:0] exp_line;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && obs_pc.size() < 4; i++) step();
    total++;
    if (obs_pc.size() < 4) begin
      bad++; $display("FAIL cold_timeout: got %0d entries want 4", obs_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (obs_pc[i] !== 32'h3000_0000 + 32'(4 * i)) begin bad++; $display("FAIL cold_pc%0d: got %h want %h", i, obs_pc[i], 32'h3000_0000 + 32'(4 * i)); end
        total++; if (obs_inst[i] !== mem_f(32'h3000_0000 + 32'(4 * i))) begin bad++; $display("FAIL cold_inst%0d: got %h", i, obs_inst[i]); end
        total++; if (obs_fault[i] !== 1'b0) begin bad++; $display("FAIL cold_fault%0d: got %b want 0", i, obs_fault[i]); end
      end
      for (int i = 0; i < 3; i++) begin
        total++; if (obs_cyc[i+1] - obs_cyc[i] != 1) begin bad++; $display("FAIL cold_rate%0d: got gap %0d want 1", i, obs_cyc[i+1] - obs_cyc[i]); end
      end
    end
    total++;
    if (ar_addr_q.size() != 1) begin
      bad++; $display("FAIL cold_ar_count: got %0d want 1", ar_addr_q.size());
    end else begin
      total++; if (ar_addr_q[0] !== 32'h3000_0000) begin bad++; $display("FAIL cold_araddr: got %h want 30000000", ar_addr_q[0]); end
      total++; if (ar_len_q[0] !== 8'd3) begin bad++; $display("FAIL cold_arlen: got %0d want 3", ar_len_q[0]); end
      total++; if (ar_burst_q[0] !== 2'b01) begin bad++; $display("FAIL cold_arburst: got %b want 01", ar_burst_q[0]); end
      total++; if (ar_id_q[0] !== 4'h0) begin bad++; $display("FAIL cold_arid: got %h want 0", ar_id_q[0]); end
      total++; if (ar_size_q[0] !== 3'b010) begin bad++; $display("FAIL cold_arsize: got %b want 010", ar_size_q[0]); end
    end
    total++; if (r_beats != 4) begin bad++; $display("FAIL cold_beats: got %0d want 4", r_beats); end
    total++;
    if (rf_addr_q.size() != 1) begin
      bad++; $display("FAIL cold_refill_count: got %0d want 1", rf_addr_q.size());
    end else begin
      for (int i = 0; i < LW; i++) exp_line[32*i +: 32] = mem_f(32'h3000_0000 + 32'(4 * i));
      total++; if (rf_addr_q[0] !== 32'h3000_0000) begin bad++; $display("FAIL cold_refill_addr: got %h want 30000000", rf_addr_q[0]); end
      total++; if (rf_data_q[0] !== exp_line) begin bad++; $display("FAIL cold_refill_data: got %h want %h", rf_data_q[0], exp_line); end
    end
  endtask

  task automatic test_single_region();
    do_reset();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h2000_0010;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 200 && rf_addr_q.size() < 1; i++) step();
    total++;
    if (ar_addr_q.size() != 4) begin
      bad++; $display("FAIL single_ar_count: got %0d want 4", ar_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (ar_addr_q[i] !== 32'h2000_0010 + 32'(4 * i)) begin bad++; $display("FAIL single_araddr%0d: got %h want %h", i, ar_addr_q[i], 32'h2000_0010 + 32'(4 * i)); end
        total++; if (ar_len_q[i] !== 8'd0 || ar_burst_q[i] !== 2'b00) begin bad++; $display("FAIL single_arlen_burst%0d: got %0d/%b want 0/00", i, ar_len_q[i], ar_burst_q[i]); end
      end
    end
    total++;
    if (rf_addr_q.size() != 1) begin bad++; $display("FAIL single_refill_count: got %0d want 1", rf_addr_q.size()); end
    else if (rf_addr_q[0] !== 32'h2000_0010) begin bad++; $display("FAIL single_refill_addr: got %h want 20000010", rf_addr_q[0]); end
    for (int i = 0; i < 50 && obs_pc.size() < 1; i++) step();
    total++;
    if (obs_pc.size() < 1) begin bad++; $display("FAIL single_first_out: got none want 20000010"); end
    else if (obs_pc[0] !== 32'h2000_0010 || obs_inst[0] !== mem_f(32'h2000_0010)) begin
      bad++; $display("FAIL single_first_out: got %h/%h want 20000010/%h", obs_pc[0], obs_inst[0], mem_f(32'h2000_0010));
    end
  endtask

  task automatic test_iq_full();
    do_reset();
    for (int i = 0; i < 4; i++) install(32'h3000_0000 + 32'(16 * i));
    refresh_ic();
    out_ready = 1'b0;
    repeat (10) step();
    total++; if (ic_addr !== 32'h3000_0010) begin bad++; $display("FAIL full_fetch_pc: got %h want 30000010", ic_addr); end
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h3000_0000) begin bad++; $display("FAIL full_head: got %b/%h want 1/30000000", out_valid, out_pc); end
    total++; if (ar_addr_q.size() != 0) begin bad++; $display("FAIL full_no_ar: got %0d want 0", ar_addr_q.size()); end
    out_ready = 1'b1;
    for (int i = 0; i < 100 && obs_pc.size() < 8; i++) step();
    total++;
    if (obs_pc.size() < 8) begin
      bad++; $display("FAIL full_drain_timeout: got %0d want 8", obs_pc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++; if (obs_pc[i] !== 32'h3000_0000 + 32'(4 * i) || obs_inst[i] !== mem_f(32'h3000_0000 + 32'(4 * i))) begin
          bad++; $display("FAIL full_drain%0d: got %h want %h", i, obs_pc[i], 32'h3000_0000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect_in_r();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && r_beats < 2; i++) step();
    total++; if (r_beats != 2 || rready !== 1'b1) begin bad++; $display("FAIL redir_mid_r: got beats=%0d rready=%b want 2/1", r_beats, rready); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 100 && rf_addr_q.size() < 1; i++) step();
    total++;
    if (rf_addr_q.size() < 1) begin bad++; $display("FAIL redir_refill: got none want 30000000"); end
    else if (rf_addr_q[0] !== 32'h3000_0000) begin bad++; $display("FAIL redir_refill: got %h want 30000000", rf_addr_q[0]); end
    total++; if (r_beats != 4) begin bad++; $display("FAIL redir_beats: got %0d want 4", r_beats); end
    for (int i = 0; i < 200 && obs_pc.size() < 1; i++) step();
    total++;
    if (obs_pc.size() < 1) begin bad++; $display("FAIL redir_first_out: got none want 80000040"); end
    else if (obs_pc[0] !== 32'h8000_0040) begin bad++; $display("FAIL redir_first_out: got %h want 80000040", obs_pc[0]); end
    total++;
    if (ar_addr_q.size() < 2) begin bad++; $display("FAIL redir_new_ar: got %0d ARs want 2", ar_addr_q.size()); end
    else if (ar_addr_q[1] !== 32'h8000_0040 || ar_len_q[1] !== 8'd3) begin bad++; $display("FAIL redir_new_ar: got %h/%0d want 80000040/3", ar_addr_q[1], ar_len_q[1]); end
  endtask

  task automatic test_fault();
    do_reset();
    err_addr = 32'h3000_0004;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && obs_pc.size() < 1; i++) step();
    total++;
    if (obs_pc.size() < 1) begin bad++; $display("FAIL fault_entry: got none want 30000000"); end
    else if (obs_pc[0] !== 32'h3000_0000 || obs_fault[0] !== 1'b1 || obs_inst[0] !== 32'h0) begin
      bad++; $display("FAIL fault_entry: got %h/%b/%h want 30000000/1/0", obs_pc[0], obs_fault[0], obs_inst[0]);
    end
    repeat (20) step();
    total++; if (obs_pc.size() != 1) begin bad++; $display("FAIL fault_halt_entries: got %0d want 1", obs_pc.size()); end
    total++; if (ar_addr_q.size() != 1) begin bad++; $display("FAIL fault_halt_ar: got %0d want 1", ar_addr_q.size()); end
    total++; if (rf_addr_q.size() != 0) begin bad++; $display("FAIL fault_no_refill: got %0d want 0", rf_addr_q.size()); end
    err_addr = '1;
    redirect_valid = 1'b1; redirect_pc = 32'h2000_0000;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 50 && ar_addr_q.size() < 2; i++) step();
    total++;
    if (ar_addr_q.size() < 2) begin bad++; $display("FAIL fault_resume: got %0d ARs want 2", ar_addr_q.size()); end
    else if (ar_addr_q[1] !== 32'h2000_0000) begin bad++; $display("FAIL fault_resume: got %h want 20000000", ar_addr_q[1]); end
  endtask

  task automatic test_redirect_full_deq();
    do_reset();
    for (int i = 0; i < 4; i++) install(32'h3000_0000 + 32'(16 * i));
    refresh_ic();
    out_ready = 1'b0;
    repeat (8) step();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h3000_0020;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_count_zero: got out_valid %b want 0", out_valid); end
    total++; if (obs_pc.size() != 0) begin bad++; $display("FAIL flush_no_deq: got %0d want 0", obs_pc.size()); end
    for (int i = 0; i < 50 && obs_pc.size() < 1; i++) step();
    total++;
    if (obs_pc.size() < 1) begin bad++; $display("FAIL flush_first_out: got none want 30000020"); end
    else if (obs_pc[0] !== 32'h3000_0020) begin bad++; $display("FAIL flush_first_out: got %h want 30000020", obs_pc[0]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_start();
    test_single_region();
    test_iq_full();
    test_redirect_in_r();
    test_fault();
    test_redirect_full_deq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_line_prefetch.md
Name: ifu_line_prefetch

Overview:
Next-generation instruction fetch unit with three additions: a parametrised instruction queue (IQ) that decouples fetch from decode, configurable refill line length, and clean redirect handling while a refill is in flight. It looks up the I-cache at the fetch PC and enqueues {pc, inst} on a hit. On a miss it refills one line over AXI4 read: one INCR burst inside the burst region, one single-beat request per word elsewhere. It sits between the PC/redirect logic from EXU and the IDU, beside the I-cache array.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; power of two, range 1..16
IQ_DEPTH, 4, IQ entries; power of two, range 2..16
RESET_PC, 32'h3000_0000, fetch PC after reset
BURST_LO, 4'hA, lowest addr[31:28] of the burst-capable region
BURST_HI, 4'hB, highest addr[31:28] of the burst-capable region
AXI_ID, 4'h0, constant arid value

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
redirect_valid  in  1  redirect fetch to redirect_pc
redirect_pc  in  32  redirect target
out_valid  out  1  IQ head valid toward IDU
out_ready  in  1  IDU accepts the head entry
out_pc  out  32  PC of the head entry
out_inst  out  32  instruction of the head entry
out_fault  out  1  head entry carries an access fault
ic_addr  out  32  I-cache lookup address; equals fetch_pc
ic_hit  in  1  lookup hit (combinational from the array)
ic_data  in  32  instruction word on hit
refill_valid  out  1  one-cycle line write strobe to the I-cache
refill_addr  out  32  line base address
refill_data  out  32*LINE_WORDS  line data; word i at bits [32i+31:32i]
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  32  AXI AR address
arid  out  4  AXI AR id; always AXI_ID
arlen  out  8  AXI AR length
arsize  out  3  AXI AR size; always 3'b010
arburst  out  2  AXI AR burst type
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rdata  in  32  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last beat

Behaviour:
Reset values
- fetch_pc = RESET_PC; IQ empty.
- State LOOKUP; beat = 0; fault_acc = 0; halted = 0.
- arvalid, rready, refill_valid = 0; refill_data = 0.

Line addressing and mode
- base = {fetch_pc[31:log2(LINE_WORDS*4)], zeros}.
- burst = base[31:28] within [BURST_LO, BURST_HI].

IQ
- Circular buffer with a count register of log2(IQ_DEPTH)+1 bits.
- Enqueue is allowed only when count < IQ_DEPTH; there is no bypass when full, even if a dequeue occurs the same cycle.
- out_valid = (count != 0) & ~redirect_valid.
- Dequeue on out_valid & out_ready.
- Hit throughput: 1 instruction per cycle.

Redirect (highest priority, any state)
- Same cycle: IQ flushed (count = 0 next cycle); fetch_pc <= redirect_pc; halted <= 0.
- A lookup hit in the redirect cycle is not enqueued.
- An outstanding AXI transaction always completes: arvalid, once high, holds until arready, and all beats are accepted.
- The line is still written on completion if fault_acc = 0.
- No instruction from the old path is enqueued after the redirect.

States
- LOOKUP, when not halted:
  - hit and IQ not full: enqueue {fetch_pc, ic_data, 0}; fetch_pc += 4.
  - miss and IQ not full: latch base/burst, beat = 0, fault_acc = 0, go to AR.
- AR:
  - arvalid = 1.
  - Burst: araddr = base, arlen = LINE_WORDS-1, arburst = INCR (2'b01).
  - Single: araddr = base + 4*beat, arlen = 0, arburst = FIXED (2'b00).
  - On arready: go to R.
- R:
  - rready = 1.
  - Each beat: refill_data word[beat] <= rdata; fault_acc |= (rresp != 0); beat++.
  - Burst: go to FILL on rlast.
  - Single: go to FILL when beat == LINE_WORDS-1, otherwise back to AR.
- FILL, one cycle, then LOOKUP:
  - If fault_acc = 0: refill_valid = 1 with refill_addr = base; the next lookup hits.
  - If fault_acc = 1: no refill write. If no redirect has occurred since the miss, enqueue {fetch_pc, 32'h0, 1} (waiting for a free slot if the IQ is full) and set halted = 1.
  - While halted, no lookups are enqueued and no misses start until a redirect.

Reset mid-transaction: everything returns to its reset values immediately; AXI handshake state is lost by design (the interconnect is reset together).

Test Plan:
- Cold start, RESET_PC in the burst region, LINE_WORDS=4, miss → exactly one AR with arlen=3 and arburst=1; 4 beats; refill_valid pulses once with refill_addr=RESET_PC; the IQ then outputs PC 0x30000000, 0x30000004, ... one per cycle with out_ready=1.
- Miss at 0x2000_0010 (outside the burst region) → four AR requests to 0x2000_0010/14/18/1C, each with arlen=0 and arburst=0, then one refill_valid.
- out_ready=0 with continuous hits → IQ fills to IQ_DEPTH with fetch_pc advanced by 4*IQ_DEPTH, then stalls. Release → in-order drain with no loss or duplication.
- redirect_valid to 0x8000_0040 during R with 2 of 4 beats received → remaining beats accepted; line written; no old-path entry emitted; the first out_pc after the redirect is 0x8000_0040.
- rresp=2'b10 on beat 1 → no refill_valid; one entry with out_fault=1 and out_pc = miss PC; no further AR until a redirect.
- Redirect in the same cycle as out_valid & out_ready with a full IQ → out_valid forced low that cycle; the next cycle has count=0.
